// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display path.
// Segment vectors are ordered {a,b,c,d,e,f,g} with a in the MSB; all patterns are active-low.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    // One registered display state: segments plus the decimal point, both active-low.
    typedef struct packed {
        seg_t seg;
        logic p;
    } disp_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Index 0 is the first element; every code is defined so nothing decodes to X.
    localparam seg_t SEG_HEX [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    localparam disp_t DISP_DARK = '{seg: SEG_BLANK, p: 1'b1};

endpackage

// File: rtl/my_mc14495_if.sv
// Pin bundle between display-scan logic and the MC14495-style decoder.
// The driver side owns the nibble/blank/point inputs; the decoder owns the segment drives.
interface my_mc14495_if;

    logic D0;
    logic D1;
    logic D2;
    logic D3;
    logic LE;
    logic point;
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
    logic p;

    modport master (
        output D0, D1, D2, D3, LE, point,
        input  a, b, c, d, e, f, g, p
    );

    modport slave (
        input  D0, D1, D2, D3, LE, point,
        output a, b, c, d, e, f, g, p
    );

endinterface

// File: rtl/hex2seg.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex2seg
    import seg7_pkg::*;
(
    input  nibble_t nibble,
    output seg_t    seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/my_mc14495.sv
// Registered hex-to-seven-segment decoder for a common-anode digit.
// Inputs sampled at a rising edge appear on the segment pins right after that edge.
module my_mc14495
    import seg7_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    my_mc14495_if.slave   bus
);

    nibble_t nibble;
    seg_t    dec_seg;
    disp_t   disp_d;
    disp_t   disp_q;

    assign nibble = {bus.D3, bus.D2, bus.D1, bus.D0};

    hex2seg u_hex2seg (
        .nibble (nibble),
        .seg    (dec_seg)
    );

    // Blanking overrides the decoder but leaves the point alone.
    always_comb begin
        // NOTE: assign a default to every always_comb output first so no path can infer a latch.
        disp_d     = DISP_DARK;
        disp_d.seg = bus.LE ? SEG_BLANK : dec_seg;
        disp_d.p   = ~bus.point;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            disp_q <= DISP_DARK;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign bus.a = disp_q.seg[6];
    assign bus.b = disp_q.seg[5];
    assign bus.c = disp_q.seg[4];
    assign bus.d = disp_q.seg[3];
    assign bus.e = disp_q.seg[2];
    assign bus.f = disp_q.seg[1];
    assign bus.g = disp_q.seg[0];
    assign bus.p = disp_q.p;

endmodule

// File: tb/tb_my_mc14495.sv
// Self-checking bench for my_mc14495: vector table driven through a one-deep scoreboard queue,
// plus hand sequences for blanking, simultaneous input changes and mid-stream reset.
module tb_my_mc14495;

    typedef struct {
        logic       rst;
        logic [3:0] n;
        logic       le;
        logic       point;
        logic [6:0] seg;
        logic       p;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    vec_t vecs[$];
    vec_t sb[$];

    my_mc14495_if bus ();

    my_mc14495 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference patterns written out independently from the datasheet table.
    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] n, input logic le,
                                input logic pt, input logic [6:0] seg, input logic p,
                                input string name);
        vec_t v;
        v.rst = r; v.n = n; v.le = le; v.point = pt; v.seg = seg; v.p = p; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got abcdefg_p=%b want %b", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pins();
        return {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.p};
    endfunction

    task automatic drive(input vec_t v);
        rst       = v.rst;
        bus.D0    = v.n[0];
        bus.D1    = v.n[1];
        bus.D2    = v.n[2];
        bus.D3    = v.n[3];
        bus.LE    = v.le;
        bus.point = v.point;
    endtask

    // Drive on the falling edge, push the expectation, compare just after the next rising edge.
    task automatic apply(input vec_t v);
        vec_t exp;
        @(negedge clk);
        drive(v);
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            exp = sb.pop_front();
            check(exp.name, pins(), {exp.seg, exp.p});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;

        // Reset with N=8, point=1 held for two cycles, then release.
        vecs.push_back(mk(1'b1, 4'd8, 1'b0, 1'b1, 7'b1111111, 1'b1, "reset_c0"));
        vecs.push_back(mk(1'b1, 4'd8, 1'b0, 1'b1, 7'b1111111, 1'b1, "reset_c1"));
        vecs.push_back(mk(1'b0, 4'd8, 1'b0, 1'b1, 7'b0000000, 1'b0, "reset_release"));

        // Full sweep with point = N[0]; a one-cycle reset is inserted at N=7.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] n;
            n = 4'(i);
            if (i == 7)
                vecs.push_back(mk(1'b1, n, 1'b0, n[0], 7'b1111111, 1'b1, "midreset_n7"));
            vecs.push_back(mk(1'b0, n, 1'b0, n[0], ref_seg(n), ~n[0],
                              $sformatf("sweep_n%0d", i)));
        end

        // Blanking keeps the point; dropping LE restores the digit.
        vecs.push_back(mk(1'b0, 4'd15, 1'b1, 1'b1, 7'b1111111, 1'b0, "blank_f"));
        vecs.push_back(mk(1'b0, 4'd15, 1'b0, 1'b1, 7'b0111000, 1'b0, "unblank_f"));

        // Blank state with N=3 ahead of the simultaneous change.
        vecs.push_back(mk(1'b0, 4'd3, 1'b1, 1'b0, 7'b1111111, 1'b1, "simul_pre"));

        foreach (vecs[i]) apply(vecs[i]);

        // Switch N 3->12, point 0->1, LE 1->0 together: pins hold the old blank state until the edge.
        @(negedge clk);
        v = mk(1'b0, 4'd12, 1'b0, 1'b1, 7'b0110001, 1'b0, "simul_after");
        drive(v);
        sb.push_back(v);
        #1;
        check("simul_hold", pins(), {7'b1111111, 1'b1});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL simul_after: scoreboard empty");
        end else begin
            v = sb.pop_front();
            check(v.name, pins(), {v.seg, v.p});
        end

        // Reset overrides blanking and point, then decoding resumes immediately.
        apply(mk(1'b1, 4'd10, 1'b1, 1'b1, 7'b1111111, 1'b1, "reset_over_le"));
        apply(mk(1'b0, 4'd10, 1'b0, 1'b1, 7'b0001000, 1'b0, "resume_a"));

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/my_mc14495.md
# my_mc14495

Registered hexadecimal-to-seven-segment decoder modelled on the MC14495 part. It takes a 4-bit nibble on discrete pins plus a decimal-point request and a blanking control. It drives active-low segment lines a–g and an active-low point line for a common-anode digit. It sits between the display-scan logic and the board's segment pins.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- D0  in  1  nibble bit 0 (LSB).
- D1  in  1  nibble bit 1.
- D2  in  1  nibble bit 2.
- D3  in  1  nibble bit 3 (MSB).
- LE  in  1  blank enable; 1 = all segments a–g off.
- point  in  1  decimal-point request; 1 = point lit.
- a, b, c, d, e, f, g  out  1 each  segment drives, active-low (0 = lit).
- p  out  1  decimal-point drive, active-low (0 = lit).

## Operation
- Nibble N = {D3,D2,D1,D0}.
- Segment patterns, given as a..g with 0 = lit:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- LE = 1: a–g all 1, regardless of N. LE has priority over decode.
- p = ~point. p is not affected by LE.
- No X propagation: all 16 codes are defined, with no default-to-X case.

## Timing
- Outputs are registered. An input sampled at edge k appears on the outputs immediately after edge k, a latency of 1 cycle.
- rst = 1 at an edge forces a–g = 1111111 and p = 1 (display dark), overriding all inputs.
- Decoding resumes on the first edge with rst = 0.
- Reset asserted mid-stream takes effect at that edge; no pending value survives it.
- Simultaneous input changes (N, LE, point in the same cycle) are all reflected together one cycle later. Glitch-free: segment outputs change only at clock edges.
- Power-up before the first reset: undefined. The bench must apply reset first.

## Structure
- Shared package `seg7_pkg` holds:
  - typedef `seg_t` (7-bit, a in MSB).
  - constant array `SEG_HEX[16]` of active-low patterns.
  - constant `SEG_BLANK = 7'b1111111`.
- One sub-module is natural: `hex2seg`, a purely combinational decoder with nibble in, `seg_t` out.
- The top module contains:
  - input packing.
  - LE muxing.
  - point inversion.
  - the output register with synchronous reset.
  - unpacking to the named pins.

## Test plan
- Reset: hold rst = 1 with N = 8, point = 1, LE = 0 for 2 cycles. Required response: a–g = 1111111, p = 1. Release rst; one cycle later a–g = 0000000, p = 0.
- Full sweep: LE = 0, N = 0..15, one per cycle, point = N[0]. Each output lags its input by exactly 1 cycle and matches the table. Examples:
  - N = 0 gives 0000001, p = 1.
  - N = 5 gives 0100100, p = 0.
  - N = 11 gives 1100000, p = 0.
  - N = 15 gives 0111000, p = 0.
- Blanking: N = 15, point = 1, LE = 1. Required response one cycle later: a–g = 1111111, p = 0. Drop LE; the next cycle shows 0111000.
- Simultaneous change: in one cycle switch N 3→12, point 0→1 and LE 1→0. One cycle later a–g = 0110001 and p = 0. The intervening cycle still shows the old blank state with p = 1.
- Mid-stream reset: during the sweep at N = 7, assert rst for 1 cycle. Required response on that edge: a–g = 1111111, p = 1. The next cycle decodes the current N.
